// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
package stream_mux_pkg;

  typedef enum logic [1:0] {
    ARB_RR     = 2'b00,
    ARB_FIXED  = 2'b01,
    ARB_MANUAL = 2'b10
  } arb_mode_e;

  // Increment with wrap, valid for any channel count (not just powers of two).
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational channel arbiter: round-robin, fixed-priority or manual select.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  input  logic [1:0]        mode,
  input  logic [SEL_W-1:0]  man_sel,
  output logic [NUM_CH-1:0] grant_onehot,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              grant_valid
);

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    case (mode)
      ARB_FIXED: begin
        // Scan downward so the lowest requesting index is the last one written.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
          if (req[i]) begin
            grant_valid = 1'b1;
            grant_idx   = SEL_W'(i);
          end
        end
      end
      ARB_MANUAL: begin
        if (int'(man_sel) < NUM_CH) begin
          grant_valid = req[man_sel];
          grant_idx   = man_sel;
        end
      end
      default: begin
        // Round-robin (reserved encoding included): nearest request at or after ptr wins.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
          int idx;
          idx = (int'(ptr) + k) % NUM_CH;
          if (req[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = SEL_W'(idx);
          end
        end
      end
    endcase
    grant_onehot = grant_valid ? (NUM_CH'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N:1 valid/ready stream multiplexer with selectable arbitration and a one-entry
// registered output stage.
module rr_stream_mux
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   mode,
  input  logic [SEL_W-1:0]             man_sel,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH-1:0][WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]            in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  output logic [SEL_W-1:0]             out_ch,
  input  logic                         out_ready
);

  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0] grant_onehot;
  logic [SEL_W-1:0]  grant_idx;
  logic              grant_valid;
  logic              load_en;
  logic              xfer;
  logic              is_rr;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_arbiter (
    .req          (in_valid),
    .ptr          (rr_ptr_q),
    .mode         (mode),
    .man_sel      (man_sel),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .grant_valid  (grant_valid)
  );

  assign is_rr   = (mode != ARB_FIXED) && (mode != ARB_MANUAL);
  assign load_en = !out_valid || out_ready;
  // A grant implies the winner is valid, so grant_valid alone qualifies the transfer.
  assign xfer    = rst_n && load_en && grant_valid;
  assign in_ready = xfer ? grant_onehot : '0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer && is_rr) begin
      rr_ptr_d = SEL_W'(next_idx(int'(grant_idx), NUM_CH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= in_data[grant_idx];
        out_ch    <= grant_idx;
      end else if (load_en) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Self-checking bench for rr_stream_mux: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_rr_stream_mux;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT A: 4 channels x 8 bits
  logic [1:0]      mode;
  logic [1:0]      man_sel;
  logic [3:0]      in_valid;
  logic [3:0][7:0] in_data;
  logic [3:0]      in_ready;
  logic            out_valid;
  logic [7:0]      out_data;
  logic [1:0]      out_ch;
  logic            out_ready;

  // DUT B: 3 channels x 16 bits
  logic [1:0]       mode_b;
  logic [1:0]       man_sel_b;
  logic [2:0]       in_valid_b;
  logic [2:0][15:0] in_data_b;
  logic [2:0]       in_ready_b;
  logic             out_valid_b;
  logic [15:0]      out_data_b;
  logic [1:0]       out_ch_b;
  logic             out_ready_b;

  int tests = 0;
  int fails = 0;

  rr_stream_mux #(.NUM_CH(4), .WIDTH(8)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .man_sel   (man_sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  rr_stream_mux #(.NUM_CH(3), .WIDTH(16)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode_b),
    .man_sel   (man_sel_b),
    .in_valid  (in_valid_b),
    .in_data   (in_data_b),
    .in_ready  (in_ready_b),
    .out_valid (out_valid_b),
    .out_data  (out_data_b),
    .out_ch    (out_ch_b),
    .out_ready (out_ready_b)
  );

  // Reference model for DUT A: accepted words queue up until delivered downstream.
  typedef struct {
    logic [7:0] data;
    logic [1:0] ch;
  } word_t;

  word_t m_q[$];
  int    m_ptr;

  function automatic int exp_grant();
    int g;
    g = -1;
    if (mode == 2'b01) begin
      for (int i = 0; i < 4 && g < 0; i++) if (in_valid[i]) g = i;
    end else if (mode == 2'b10) begin
      if (in_valid[man_sel]) g = int'(man_sel);
    end else begin
      for (int k = 0; k < 4 && g < 0; k++) if (in_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
    end
    return g;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    bit ld;
    g  = exp_grant();
    ld = (m_q.size() == 0) || out_ready;
    if (rst_n && ld && g >= 0) return 4'(1 << g);
    return 4'b0000;
  endfunction

  // Clock one edge and update the model with what the spec says should happen.
  task automatic advance();
    int    g;
    bit    ld;
    word_t w;
    g  = exp_grant();
    ld = (m_q.size() == 0) || out_ready;
    w.data = 8'h00;
    w.ch   = 2'd0;
    if (g >= 0) begin
      w.data = in_data[g];
      w.ch   = g[1:0];
    end
    @(posedge clk);
    if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
    if (ld && g >= 0) begin
      m_q.push_back(w);
      if (mode != 2'b01 && mode != 2'b10) m_ptr = (g + 1) % 4;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_q.delete();
    m_ptr = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    mode = 2'b00; man_sel = 2'd0; out_ready = 1'b1; in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) in_data[i] = 8'(8'hA0 + i);
    rst_n = 1'b0;
    m_q.delete();
    m_ptr = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      tests++;
      if (in_ready !== 4'b0000) begin fails++; $display("FAIL reset_in_ready got %b exp 0000", in_ready); end
      tests++;
      if (out_data !== 8'h00) begin fails++; $display("FAIL reset_out_data got %h exp 00", out_data); end
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    tests++;
    if (in_ready !== 4'b0001) begin fails++; $display("FAIL first_ready got %b exp 0001", in_ready); end
    advance();
    tests++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'hA0) begin
      fails++;
      $display("FAIL first_word got v=%b ch=%0d d=%h exp v=1 ch=0 d=a0", out_valid, out_ch, out_data);
    end
  endtask

  task automatic test_rr_fairness();
    mode = 2'b00; out_ready = 1'b1; in_valid = 4'b1111;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      advance();
      tests++;
      if (out_valid !== 1'b1 || out_ch !== 2'(k % 4) || out_data !== 8'(8'hA0 + k % 4)) begin
        fails++;
        $display("FAIL rr_fair[%0d] got v=%b ch=%0d d=%h exp v=1 ch=%0d d=%h",
                 k, out_valid, out_ch, out_data, k % 4, 8'(8'hA0 + k % 4));
      end
    end
  endtask

  task automatic test_fixed_backpressure();
    mode = 2'b01; in_valid = 4'b1010; out_ready = 1'b1;
    advance();
    tests++;
    if (out_ch !== 2'd1 || out_data !== 8'hA1) begin
      fails++; $display("FAIL fixed_load got ch=%0d d=%h exp ch=1 d=a1", out_ch, out_data);
    end
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      tests++;
      if (in_ready !== 4'b0000) begin fails++; $display("FAIL bp_ready got %b exp 0000", in_ready); end
      advance();
      tests++;
      if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 8'hA1) begin
        fails++; $display("FAIL bp_hold got v=%b ch=%0d d=%h exp v=1 ch=1 d=a1", out_valid, out_ch, out_data);
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      tests++;
      if (in_ready !== 4'b0010) begin fails++; $display("FAIL fixed_ready got %b exp 0010", in_ready); end
      advance();
      tests++;
      if (out_valid !== 1'b1 || out_ch !== 2'd1) begin
        fails++; $display("FAIL fixed_again got v=%b ch=%0d exp v=1 ch=1", out_valid, out_ch);
      end
    end
  endtask

  task automatic test_manual();
    mode = 2'b10; man_sel = 2'd2; in_valid = 4'b0011; out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 4'b0000) begin fails++; $display("FAIL man_nogrant got %b exp 0000", in_ready); end
    advance();
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL man_drop got v=%b exp 0", out_valid); end
    in_valid = 4'b0111;
    in_data[2] = 8'h5C;
    #1;
    tests++;
    if (in_ready !== 4'b0100) begin fails++; $display("FAIL man_ready got %b exp 0100", in_ready); end
    advance();
    tests++;
    if (out_valid !== 1'b1 || out_data !== 8'h5C || out_ch !== 2'd2) begin
      fails++; $display("FAIL man_word got v=%b ch=%0d d=%h exp v=1 ch=2 d=5c", out_valid, out_ch, out_data);
    end
  endtask

  task automatic test_wrap3();
    logic [1:0] ech;
    in_valid = 4'b0000;
    mode_b = 2'b00; man_sel_b = 2'd0; out_ready_b = 1'b1; in_valid_b = 3'b101;
    for (int i = 0; i < 3; i++) in_data_b[i] = 16'(16'h1000 + i);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      ech = (k % 2 == 1) ? 2'd2 : 2'd0;
      #1;
      tests++;
      if (in_ready_b !== 3'(1 << ech)) begin
        fails++; $display("FAIL wrap_ready[%0d] got %b exp %b", k, in_ready_b, 3'(1 << ech));
      end
      @(posedge clk);
      #1;
      tests++;
      if (out_valid_b !== 1'b1 || out_ch_b !== ech || out_data_b !== 16'(16'h1000 + ech)) begin
        fails++;
        $display("FAIL wrap_word[%0d] got v=%b ch=%0d d=%h exp v=1 ch=%0d d=%h",
                 k, out_valid_b, out_ch_b, out_data_b, ech, 16'(16'h1000 + ech));
      end
    end
    in_valid_b = 3'b000;
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      mode      = 2'($urandom_range(0, 3));
      man_sel   = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      tests++;
      if (in_ready !== exp_ready()) begin
        fails++; $display("FAIL rand_ready[%0d] got %b exp %b", cyc, in_ready, exp_ready());
      end
      advance();
      tests++;
      if (out_valid !== (m_q.size() != 0)) begin
        fails++; $display("FAIL rand_valid[%0d] got %b exp %b", cyc, out_valid, m_q.size() != 0);
      end else if (m_q.size() != 0) begin
        tests++;
        if (out_data !== m_q[0].data || out_ch !== m_q[0].ch) begin
          fails++;
          $display("FAIL rand_word[%0d] got ch=%0d d=%h exp ch=%0d d=%h",
                   cyc, out_ch, out_data, m_q[0].ch, m_q[0].data);
        end
      end
      if (cyc == 1000) begin
        // Asynchronous reset mid-stream: any held word is discarded.
        #2 rst_n = 1'b0;
        m_q.delete();
        m_ptr = 0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
          fails++; $display("FAIL rand_reset got v=%b rdy=%b exp v=0 rdy=0000", out_valid, in_ready);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    mode_b = 2'b00; man_sel_b = 2'd0; in_valid_b = 3'b000; in_data_b = '0; out_ready_b = 1'b1;
    test_reset();
    test_rr_fairness();
    test_fixed_backpressure();
    test_manual();
    test_wrap3();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
